// File: rtl/fpu_fp64_to_int.sv
// IEEE-754 binary64 to signed 64-bit integer converter with an iterative 8-bit denormalising shifter.
// Define FPU_FP64_CVT_ROUND_EN for round-to-nearest-even; the default build truncates toward zero.
module fpu_fp64_to_int (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] src,
   output logic [63:0] dst,
   output logic        busy,
   output logic        done,
   output logic        inexact,
   output logic        invalid
);

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, NEGATE} state_t;

   localparam logic [63:0] MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MAX_NEG = 64'h8000_0000_0000_0000;
`ifdef FPU_FP64_CVT_ROUND_EN
   localparam state_t POST_SHIFT = ROUND;
`else
   localparam state_t POST_SHIFT = NEGATE;
`endif

   state_t      state, stateNext;
   logic [63:0] acc, accNext;
   logic [5:0]  cnt, cntNext;
   logic        dirLeft, dirLeftNext;
   logic        sign, signNext;
   logic        guard, guardNext;
   logic        sticky, stickyNext;
   logic [63:0] dstNext;
   logic        doneNext, inexactNext, invalidNext;

   logic               sIn;
   logic [10:0]        eIn;
   logic [51:0]        fracIn;
   logic signed [12:0] expU;
   logic [5:0]         kAmt;
   logic [63:0]        accPreLast;
   logic [63:0]        lostLow;

   assign sIn    = src[63];
   assign eIn    = src[62:52];
   assign fracIn = src[51:0];
   assign expU   = $signed({2'b00, eIn}) - 13'sd1023;
   assign busy   = (state != IDLE);

   // A right shift by k is done as k-1 then 1 so the last bit out lands in guard.
   assign kAmt       = (cnt > 6'd8) ? 6'd8 : cnt;
   assign accPreLast = acc >> (kAmt - 6'd1);
   assign lostLow    = acc & ((64'd1 << (kAmt - 6'd1)) - 64'd1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext   = state;
      accNext     = acc;
      cntNext     = cnt;
      dirLeftNext = dirLeft;
      signNext    = sign;
      guardNext   = guard;
      stickyNext  = sticky;
      dstNext     = dst;
      doneNext    = 1'b0;
      inexactNext = inexact;
      invalidNext = invalid;

      case (state)
         IDLE: begin
            if (start) begin
               if (eIn == 11'd0) begin
                  dstNext     = 64'd0;
                  inexactNext = (fracIn != 52'd0);
                  invalidNext = 1'b0;
                  doneNext    = 1'b1;
               end else if (eIn == 11'h7FF) begin
                  dstNext     = (fracIn != 52'd0 || sIn) ? MAX_NEG : MAX_POS;
                  inexactNext = 1'b0;
                  invalidNext = 1'b1;
                  doneNext    = 1'b1;
               end else if (expU < 13'sd0) begin
                  dstNext     = 64'd0;
                  inexactNext = 1'b1;
                  invalidNext = 1'b0;
                  doneNext    = 1'b1;
               end else if (expU >= 13'sd63) begin
                  // -2^63 is exactly representable; everything else here is out of range.
                  dstNext     = sIn ? MAX_NEG : MAX_POS;
                  inexactNext = 1'b0;
                  invalidNext = !(sIn && expU == 13'sd63 && fracIn == 52'd0);
                  doneNext    = 1'b1;
               end else begin
                  accNext    = {11'd0, 1'b1, fracIn};
                  signNext   = sIn;
                  guardNext  = 1'b0;
                  stickyNext = 1'b0;
                  if (expU >= 13'sd52) begin
                     dirLeftNext = 1'b1;
                     cntNext     = expU[5:0] - 6'd52;
                  end else begin
                     dirLeftNext = 1'b0;
                     cntNext     = 6'd52 - expU[5:0];
                  end
                  stateNext = (cntNext != 6'd0) ? SHIFT : POST_SHIFT;
               end
            end
         end
         SHIFT: begin
            if (dirLeft) begin
               accNext = acc << kAmt;
            end else begin
               accNext    = accPreLast >> 1;
               guardNext  = accPreLast[0];
               stickyNext = sticky | guard | (lostLow != 64'd0);
            end
            cntNext = cnt - kAmt;
            if (cntNext == 6'd0) stateNext = POST_SHIFT;
         end
`ifdef FPU_FP64_CVT_ROUND_EN
         ROUND: begin
            if (!dirLeft && guard && (sticky || acc[0])) accNext = acc + 64'd1;
            stateNext = NEGATE;
         end
`endif
         NEGATE: begin
            dstNext     = sign ? (~acc + 64'd1) : acc;
            inexactNext = guard | sticky;
            invalidNext = 1'b0;
            doneNext    = 1'b1;
            stateNext   = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc     <= 64'd0;
         cnt     <= 6'd0;
         dirLeft <= 1'b0;
         sign    <= 1'b0;
         guard   <= 1'b0;
         sticky  <= 1'b0;
         dst     <= 64'd0;
         done    <= 1'b0;
         inexact <= 1'b0;
         invalid <= 1'b0;
      end else begin
         acc     <= accNext;
         cnt     <= cntNext;
         dirLeft <= dirLeftNext;
         sign    <= signNext;
         guard   <= guardNext;
         sticky  <= stickyNext;
         dst     <= dstNext;
         done    <= doneNext;
         inexact <= inexactNext;
         invalid <= invalidNext;
      end
   end

endmodule

// File: tb/tb_fpu_fp64_to_int.sv
// Directed bench for fpu_fp64_to_int: hand-computed vectors, latency, busy window, special cases, reset.
module tb_fpu_fp64_to_int;

`ifdef FPU_FP64_CVT_ROUND_EN
   localparam int RND = 1;
`else
   localparam int RND = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [63:0] src = 64'd0;
   logic [63:0] dst;
   logic        busy, done, inexact, invalid;

   int total = 0;
   int passCnt = 0;

   fpu_fp64_to_int dut (
      .clk(clk), .reset(reset), .start(start), .src(src),
      .dst(dst), .busy(busy), .done(done), .inexact(inexact), .invalid(invalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Start a conversion, wait for done within a bounded window, check result, latency and busy window.
   task automatic conv(input string tag, input logic [63:0] v, input logic [63:0] eDst,
                       input logic eInex, input logic eInv, input int eCyc);
      int n;
      logic busyOk;
      @(posedge clk); #1 src = v; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 1; busyOk = 1'b1;
      while (1) begin
         @(negedge clk);
         if (done === 1'b1) break;
         if (busy !== 1'b1) busyOk = 1'b0;
         if (n >= 20) break;
         @(posedge clk);
         n++;
      end
      chk({tag, "_cycle"}, 64'(n), 64'(eCyc));
      chk({tag, "_dst"}, dst, eDst);
      chk({tag, "_inexact"}, 64'(inexact), 64'(eInex));
      chk({tag, "_invalid"}, 64'(invalid), 64'(eInv));
      chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      chk({tag, "_busy_window"}, 64'(busyOk), 64'd1);
      @(posedge clk); @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int dones;
      // start during reset must be ignored
      @(posedge clk); #1 src = 64'h7FF0_0000_0000_0000; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("rst_dst", dst, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_flags", {62'd0, inexact, invalid}, 64'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rst_start_ignored", 64'(done), 64'd0);

      conv("one",      64'h3FF0_0000_0000_0000, 64'd1, 1'b0, 1'b0, 9 + RND);
      conv("neg2p5",   64'hC004_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 9 + RND);
      conv("onep5",    64'h3FF8_0000_0000_0000, 64'd1 + 64'(RND), 1'b1, 1'b0, 9 + RND);
      conv("two60",    64'h43B0_0000_0000_0000, 64'h1000_0000_0000_0000, 1'b0, 1'b0, 3 + RND);
      conv("cnt0",     64'h4330_0000_0000_0001, 64'h0010_0000_0000_0001, 1'b0, 1'b0, 2 + RND);
      conv("posinf",   64'h7FF0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1);
      conv("neginf",   64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1);
      conv("min_int",  64'hC3E0_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1);
      conv("pos2p63",  64'h43E0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1);
      conv("half",     64'h3FE0_0000_0000_0000, 64'd0, 1'b1, 1'b0, 1);
      conv("denorm",   64'h0000_0000_0000_0001, 64'd0, 1'b1, 1'b0, 1);
      conv("negzero",  64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0, 1);
      conv("negone",   64'hBFF0_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 9 + RND);

      // start pulsed while busy is ignored: exactly one done, result of the first operand
      @(posedge clk); #1 src = 64'h3FF0_0000_0000_0000; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); @(posedge clk); #1 src = 64'h7FF0_0000_0000_0000; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
         @(posedge clk);
      end
      chk("busy_ignore_dones", 64'(dones), 64'd1);
      chk("busy_ignore_dst", dst, 64'd1);
      chk("busy_ignore_invalid", 64'(invalid), 64'd0);

      // leave nonzero outputs, then reset in cycle 4 of a 1.0 conversion
      conv("nan",      64'h7FF8_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1);
      @(posedge clk); #1 src = 64'h3FF0_0000_0000_0000; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst_dst", dst, 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_flags", {62'd0, inexact, invalid}, 64'd0);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); @(negedge clk);
         if (done === 1'b1) dones++;
      end
      chk("midrst_no_done", 64'(dones), 64'd0);
      conv("after_rst", 64'h3FF0_0000_0000_0000, 64'd1, 1'b0, 1'b0, 9 + RND);

      $display("%0d/%0d checks passed", passCnt, total);
      $finish;
   end

endmodule

// File: doc/fpu_fp64_to_int.md
# fpu_fp64_to_int

Multi-cycle converter from IEEE-754 binary64 to signed 64-bit two's-complement integer. It unpacks an FP64 operand into sign, exponent and significand, then denormalises it with an iterative shifter. This is the reverse of the FP64 add/normalise/pack path. It sits beside the FP64 adder in the FPU and serves FTRC-style float-to-integer instructions through a start/done handshake.

## Interface

Parameters:
- none.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `start`  in  1  request strobe; accepted only when `busy`=0.
- `src`  in  64  FP64 operand, sampled on the accepting edge.
- `dst`  out  64  integer result; held until the next result write.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse; `dst` and flags are valid.
- `inexact`  out  1  nonzero fraction bits were discarded.
- `invalid`  out  1  NaN, Inf, or out-of-range operand.

## Operation

Unpack:
- s=`src[63]`, e=`src[62:52]`, m={1,`src[51:0]`} (53 bits); E=e-1023, computed signed with 13 bits.

Special cases are resolved on the accepting edge and go directly to the result write:
- e=0: `dst`=0; `inexact`=(frac≠0).
- E<0 and e≠0: `dst`=0; `inexact`=1.
- e=2047, NaN: `dst`=0x8000_0000_0000_0000; `invalid`=1.
- e=2047, ±Inf: saturate. +Inf → 0x7FFF_FFFF_FFFF_FFFF; −Inf → 0x8000_0000_0000_0000. `invalid`=1.
- E≥63: saturate by sign, `invalid`=1. Exception: s=1, E=63, frac=0 gives 0x8000_0000_0000_0000 with `invalid`=0.

Normal case, 0≤E≤62:
- Accumulator acc[63:0]={11'b0,m}.
- Shift count cnt=|E−52| (0..52); direction left if E≥52, else right.

States:
- IDLE: on `start`&&!`busy`, either latch a special case (write result) or load acc/cnt/dir. Next state is SHIFT if cnt≠0, else NEGATE.
- SHIFT: shift acc by k=min(cnt,8); cnt−=k. A right shift ORs the lost bits into sticky; the last bit lost is the guard. Exit to NEGATE (or ROUND, see Configuration) when the cnt after update is 0.
- NEGATE: if s, acc=−acc. Write `dst`, `inexact`=guard|sticky, `invalid`=0. Pulse `done`. Return to IDLE.

Rules:
- `start` while `busy` is ignored. No queueing.
- Outputs change only on a result write or on reset.

## Timing

- `start` is sampled in cycle 0.
- Special case: `done`=1 in cycle 1.
- Normal case: S=ceil(cnt/8) SHIFT cycles. `done`=1 in cycle 2+S, or 3+S with rounding compiled in.
- `busy`=1 from cycle 1 through the NEGATE cycle. `busy`=0 during the `done` cycle, so a new `start` may be accepted in that cycle.
- Worst case: E=0, cnt=52, S=7 → `done` in cycle 9 (10 with rounding).
- Reset (`reset`=0 at an edge), from any state:
  - state=IDLE, cnt=0.
  - `dst`=0, `busy`=0, `done`=0, `inexact`=0, `invalid`=0.
  - An in-flight conversion is dropped and produces no `done`.
- `start` coinciding with `reset`=0 is ignored.

## Configuration

- `FPU_FP64_CVT_ROUND_EN` defined:
  - Adds a ROUND state between SHIFT/NEGATE.
  - For right-shift results, increments the magnitude when guard&&(sticky||acc[0]), i.e. round-to-nearest-even on magnitude.
  - Magnitude cannot overflow because E≤62.
  - Adds exactly one cycle to every normal-case conversion, including cnt=0 and left shifts.
- Not defined: truncation toward zero; no ROUND state. Flags are identical in both builds.

## Test plan

- 0x3FF0_0000_0000_0000 (1.0) → `dst`=1, `inexact`=0, `invalid`=0, `done` in cycle 9 (10 with rounding); `busy` high cycles 1–8.
- 0xC004_0000_0000_0000 (−2.5) → truncate: 0xFFFF_FFFF_FFFF_FFFE, `inexact`=1. Rounding: also 0xFFFF_FFFF_FFFF_FFFE (tie to even). Also 0x3FF8_0000_0000_0000 (1.5) → truncate 1, rounding 2.
- 0x43B0_0000_0000_0000 (2^60) → 0x1000_0000_0000_0000, `done` cycle 3, `inexact`=0. Also 0x4330_0000_0000_0001 (cnt=0) → 0x0010_0000_0000_0001, `done` cycle 2.
- 0x7FF0_0000_0000_0000 → 0x7FFF_FFFF_FFFF_FFFF, `invalid`=1, `done` cycle 1. 0xC3E0_0000_0000_0000 → 0x8000_0000_0000_0000, `invalid`=0. 0x7FF8_0000_0000_0000 → 0x8000_0000_0000_0000, `invalid`=1.
- 0x3FE0_0000_0000_0000 (0.5) → 0, `inexact`=1, `done` cycle 1. `start` pulsed during `busy` → ignored; only one `done`.
- Reset asserted in cycle 4 of a 1.0 conversion → next cycle: all outputs 0, `busy`=0, no `done`. A fresh `start` after reset release converts normally.
